gprs_mp: RTL and testbench

GPRS_MP -- requirements
Module: gprs_mp

---
 rtl/gprs_mp_pkg.sv | 15 +
 rtl/gprs_dbg_fsm.sv | 30 +++
 rtl/gprs_mp.sv | 90 +++++++++
 tb/tb_gprs_mp.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/gprs_mp_pkg.sv
// gprs_mp_pkg: shared constants and types for the multi-port GPR file
//   DBG_GPR_BASE   - debug register number mapped to x0
//   CMD_REGNO_SIZE - width of the debug register number
//   DATA_WIDTH_DEF - default GPR width
//   dbg_state_e    - debug handshake states
package gprs_mp_pkg;
    localparam int CMD_REGNO_SIZE = 16;
    localparam logic [CMD_REGNO_SIZE-1:0] DBG_GPR_BASE = 16'h1000;
    localparam int DATA_WIDTH_DEF = 32;
    typedef enum logic [1:0] {
        DBG_IDLE = 2'd0,
        DBG_ACK  = 2'd1,
        DBG_WAIT = 2'd2
    } dbg_state_e;
endpackage

// File: rtl/gprs_dbg_fsm.sv
// gprs_dbg_fsm: debug request handshake IDLE -> ACK -> WAIT -> IDLE
//   cpu_clk, cpu_rstn - clock, async active-low reset
//   dbg_req           - debug request level
//   dbg_accept        - access performed this cycle (IDLE with request)
//   dbg_ack           - one-cycle acknowledge, decoded from the state register
module gprs_dbg_fsm
    import gprs_mp_pkg::*;
(
    input  logic cpu_clk,
    input  logic cpu_rstn,
    input  logic dbg_req,
    output logic dbg_accept,
    output logic dbg_ack
);
    dbg_state_e state, state_nxt;
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) state <= DBG_IDLE;
        else           state <= state_nxt;
    end
    // WAIT (and the unused encoding) return to IDLE only once the request drops
    always_comb begin
        state_nxt = state == DBG_IDLE ? (dbg_req ? DBG_ACK : DBG_IDLE) :
                    state == DBG_ACK  ? DBG_WAIT :
                    (dbg_req ? DBG_WAIT : DBG_IDLE);
    end
    always_comb begin
        dbg_accept = state == DBG_IDLE && dbg_req;
        dbg_ack    = state == DBG_ACK;
    end
endmodule

// File: rtl/gprs_mp.sv
// gprs_mp: multi-port general purpose register file with pending scoreboard and debug access
//   cpu_clk, cpu_rstn            - clock, async active-low reset
//   wr0_* / wr1_*                - WB-stage and load-return write ports (wr1 wins)
//   rd_idx / rd_data / rd_busy   - packed read ports, optional same-cycle bypass, pending flag
//   iss_valid / iss_idx          - marks a destination pending at issue
//   dbg_*                        - debug register access, regno DBG_GPR_BASE + index
module gprs_mp
    import gprs_mp_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1
) (
    input  logic                           cpu_clk,
    input  logic                           cpu_rstn,
    input  logic                           wr0_valid,
    input  logic [ADDR_WIDTH-1:0]          wr0_idx,
    input  logic [DATA_WIDTH-1:0]          wr0_data,
    input  logic                           wr1_valid,
    input  logic [ADDR_WIDTH-1:0]          wr1_idx,
    input  logic [DATA_WIDTH-1:0]          wr1_data,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_idx,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]              rd_busy,
    input  logic                           iss_valid,
    input  logic [ADDR_WIDTH-1:0]          iss_idx,
    input  logic                           dbg_req,
    input  logic                           dbg_wr1_rd0,
    input  logic [CMD_REGNO_SIZE-1:0]      dbg_regno,
    input  logic [DATA_WIDTH-1:0]          dbg_write_data,
    output logic                           dbg_ack,
    output logic                           dbg_err,
    output logic [DATA_WIDTH-1:0]          dbg_read_data
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    logic [DATA_WIDTH-1:0]     regs [DEPTH];
    logic [DATA_WIDTH-1:0]     nxt  [DEPTH];
    logic [DEPTH-1:0]          pend, pend_nxt;
    logic [CMD_REGNO_SIZE-1:0] dbg_off;
    logic [ADDR_WIDTH-1:0]     dbg_idx;
    logic                      dbg_hit, dbg_accept, dbg_we;
    gprs_dbg_fsm u_fsm (
        .cpu_clk    (cpu_clk),
        .cpu_rstn   (cpu_rstn),
        .dbg_req    (dbg_req),
        .dbg_accept (dbg_accept),
        .dbg_ack    (dbg_ack)
    );
    // in range when at or above the base and the offset fits the index width
    always_comb begin
        dbg_off = dbg_regno - DBG_GPR_BASE;
        dbg_hit = dbg_regno >= DBG_GPR_BASE && (dbg_off >> ADDR_WIDTH) == '0;
        dbg_idx = dbg_off[ADDR_WIDTH-1:0];
        dbg_we  = dbg_accept && dbg_wr1_rd0 && dbg_hit;
    end
    // nxt[i] is the winning write for each register; it doubles as the bypass source
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            nxt[i] = i == 0 ? '0 :
                     dbg_we && dbg_idx == ADDR_WIDTH'(i) ? dbg_write_data :
                     wr1_valid && wr1_idx == ADDR_WIDTH'(i) ? wr1_data :
                     wr0_valid && wr0_idx == ADDR_WIDTH'(i) ? wr0_data : regs[i];
            pend_nxt[i] = i != 0 && ((iss_valid && iss_idx == ADDR_WIDTH'(i)) ||
                          (pend[i] && !(wr0_valid && wr0_idx == ADDR_WIDTH'(i)) &&
                                      !(wr1_valid && wr1_idx == ADDR_WIDTH'(i))));
        end
    end
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            pend          <= '0;
            dbg_err       <= 1'b0;
            dbg_read_data <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= nxt[i];
            pend <= pend_nxt;
            if (dbg_accept) begin
                dbg_err       <= !dbg_hit;
                dbg_read_data <= dbg_hit && !dbg_wr1_rd0 ? regs[dbg_idx] : '0;
            end
        end
    end
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ridx;
        assign ridx = rd_idx[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = BYPASS != 0 ? nxt[ridx] : regs[ridx];
        assign rd_busy[k] = pend[ridx];
    end
endmodule

// File: tb/tb_gprs_mp.sv
// tb_gprs_mp: directed self-checking bench for gprs_mp with default parameters
module tb_gprs_mp;
    localparam int DW = 32, AW = 5, NR = 2;
    logic             cpu_clk = 1'b0, cpu_rstn = 1'b0;
    logic             wr0_valid = 1'b0, wr1_valid = 1'b0;
    logic [AW-1:0]    wr0_idx = '0, wr1_idx = '0;
    logic [DW-1:0]    wr0_data = '0, wr1_data = '0;
    logic [NR*AW-1:0] rd_idx = '0;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             iss_valid = 1'b0;
    logic [AW-1:0]    iss_idx = '0;
    logic             dbg_req = 1'b0, dbg_wr1_rd0 = 1'b0;
    logic [15:0]      dbg_regno = '0;
    logic [DW-1:0]    dbg_write_data = '0;
    logic             dbg_ack, dbg_err;
    logic [DW-1:0]    dbg_read_data;
    int checks = 0, errors = 0, acks = 0;

    gprs_mp dut (
        .cpu_clk        (cpu_clk),
        .cpu_rstn       (cpu_rstn),
        .wr0_valid      (wr0_valid),
        .wr0_idx        (wr0_idx),
        .wr0_data       (wr0_data),
        .wr1_valid      (wr1_valid),
        .wr1_idx        (wr1_idx),
        .wr1_data       (wr1_data),
        .rd_idx         (rd_idx),
        .rd_data        (rd_data),
        .rd_busy        (rd_busy),
        .iss_valid      (iss_valid),
        .iss_idx        (iss_idx),
        .dbg_req        (dbg_req),
        .dbg_wr1_rd0    (dbg_wr1_rd0),
        .dbg_regno      (dbg_regno),
        .dbg_write_data (dbg_write_data),
        .dbg_ack        (dbg_ack),
        .dbg_err        (dbg_err),
        .dbg_read_data  (dbg_read_data)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic rd(input logic [AW-1:0] p0, input logic [AW-1:0] p1);
        rd_idx = {p1, p0};
        #1;
    endtask

    initial begin
        tick();
        rd(5'd5, 5'd7);
        chk("rst_ack", {31'd0, dbg_ack}, 32'd0);
        chk("rst_err", {31'd0, dbg_err}, 32'd0);
        chk("rst_rdata", dbg_read_data, 32'd0);
        chk("rst_rd0", rd_data[DW-1:0], 32'd0);
        chk("rst_busy", {30'd0, rd_busy}, 32'd0);
        cpu_rstn = 1'b1;
        tick();
        // same-cycle wr0/wr1 to x5: wr1 wins, bypassed on both ports
        wr0_valid = 1; wr0_idx = 5; wr0_data = 32'h11;
        wr1_valid = 1; wr1_idx = 5; wr1_data = 32'h22;
        rd(5'd5, 5'd5);
        chk("x5_bypass_p0", rd_data[DW-1:0], 32'h22);
        chk("x5_bypass_p1", rd_data[2*DW-1:DW], 32'h22);
        tick();
        wr0_valid = 0; wr1_valid = 0;
        rd(5'd5, 5'd5);
        chk("x5_stored", rd_data[DW-1:0], 32'h22);
        // different indexes in the same cycle both land
        wr0_valid = 1; wr0_idx = 6; wr0_data = 32'h66;
        wr1_valid = 1; wr1_idx = 8; wr1_data = 32'h88;
        tick();
        wr0_valid = 0; wr1_valid = 0;
        rd(5'd6, 5'd8);
        chk("x6_wr0", rd_data[DW-1:0], 32'h66);
        chk("x8_wr1", rd_data[2*DW-1:DW], 32'h88);
        // x0 is hardwired and never pending
        wr0_valid = 1; wr0_idx = 0; wr0_data = 32'hFFFF_FFFF;
        iss_valid = 1; iss_idx = 0;
        rd(5'd0, 5'd0);
        chk("x0_bypass", rd_data[DW-1:0], 32'd0);
        tick();
        wr0_valid = 0; iss_valid = 0;
        rd(5'd0, 5'd0);
        chk("x0_stored", rd_data[DW-1:0], 32'd0);
        chk("x0_busy", {31'd0, rd_busy[0]}, 32'd0);
        // pending: set wins over same-cycle clear, later clear drops it
        iss_valid = 1; iss_idx = 7;
        tick();
        iss_valid = 0;
        rd(5'd5, 5'd7);
        chk("x7_busy_set", {30'd0, rd_busy}, 32'd2);
        wr0_valid = 1; wr0_idx = 7; wr0_data = 32'h77;
        iss_valid = 1; iss_idx = 7;
        tick();
        wr0_valid = 0; iss_valid = 0;
        rd(5'd5, 5'd7);
        chk("x7_busy_set_wins", {31'd0, rd_busy[1]}, 32'd1);
        wr1_valid = 1; wr1_idx = 7; wr1_data = 32'h700;
        rd(5'd5, 5'd7);
        chk("x7_busy_not_bypassed", {31'd0, rd_busy[1]}, 32'd1);
        tick();
        wr1_valid = 0;
        rd(5'd5, 5'd7);
        chk("x7_busy_cleared", {31'd0, rd_busy[1]}, 32'd0);
        chk("x7_data", rd_data[2*DW-1:DW], 32'h700);
        // debug write x3, request held 4 cycles -> single ack
        dbg_req = 1; dbg_wr1_rd0 = 1; dbg_regno = 16'h1003; dbg_write_data = 32'hA5A5_A5A5;
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (dbg_ack) acks++;
        end
        chk("dbg_wr_ack_pulses", acks, 32'd1);
        chk("dbg_wr_err", {31'd0, dbg_err}, 32'd0);
        rd(5'd3, 5'd0);
        chk("x3_dbg_written", rd_data[DW-1:0], 32'hA5A5_A5A5);
        dbg_req = 0;
        tick();
        // debug read x3
        dbg_req = 1; dbg_wr1_rd0 = 0;
        tick();
        chk("dbg_rd_ack", {31'd0, dbg_ack}, 32'd1);
        chk("dbg_rd_data", dbg_read_data, 32'hA5A5_A5A5);
        chk("dbg_rd_err", {31'd0, dbg_err}, 32'd0);
        dbg_req = 0;
        tick();
        tick();
        // debug write beats wr1 on the same index, visible through the bypass
        dbg_req = 1; dbg_wr1_rd0 = 1; dbg_regno = 16'h1004; dbg_write_data = 32'h0000_000D;
        wr1_valid = 1; wr1_idx = 4; wr1_data = 32'h0000_000E;
        rd(5'd4, 5'd0);
        chk("x4_dbg_bypass", rd_data[DW-1:0], 32'h0000_000D);
        tick();
        wr1_valid = 0; dbg_req = 0;
        rd(5'd4, 5'd0);
        chk("x4_dbg_priority", rd_data[DW-1:0], 32'h0000_000D);
        tick();
        tick();
        // out-of-range debug read 0x1020
        dbg_req = 1; dbg_wr1_rd0 = 0; dbg_regno = 16'h1020;
        tick();
        chk("dbg_oor_ack", {31'd0, dbg_ack}, 32'd1);
        chk("dbg_oor_err", {31'd0, dbg_err}, 32'd1);
        chk("dbg_oor_data", dbg_read_data, 32'd0);
        rd(5'd3, 5'd4);
        chk("dbg_oor_x3_kept", rd_data[DW-1:0], 32'hA5A5_A5A5);
        dbg_req = 0;
        tick();
        tick();
        // out-of-range debug write below the base touches nothing
        dbg_req = 1; dbg_wr1_rd0 = 1; dbg_regno = 16'h0FFF; dbg_write_data = 32'hDEAD_BEEF;
        tick();
        chk("dbg_low_err", {31'd0, dbg_err}, 32'd1);
        dbg_req = 0;
        rd(5'd31, 5'd3);
        chk("dbg_low_x31", rd_data[DW-1:0], 32'd0);
        chk("dbg_low_x3", rd_data[2*DW-1:DW], 32'hA5A5_A5A5);
        tick();
        tick();
        // reset while in ACK aborts the access and clears all state
        iss_valid = 1; iss_idx = 9;
        tick();
        iss_valid = 0;
        dbg_req = 1; dbg_wr1_rd0 = 0; dbg_regno = 16'h1003;
        tick();
        chk("pre_rst_ack", {31'd0, dbg_ack}, 32'd1);
        cpu_rstn = 0;
        rd(5'd3, 5'd9);
        chk("rst_abort_ack", {31'd0, dbg_ack}, 32'd0);
        chk("rst_abort_x3", rd_data[DW-1:0], 32'd0);
        chk("rst_abort_busy", {30'd0, rd_busy}, 32'd0);
        chk("rst_abort_rdata", dbg_read_data, 32'd0);
        dbg_req = 0;
        tick();
        cpu_rstn = 1;
        tick();
        chk("post_rst_ack", {31'd0, dbg_ack}, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
